// File: rtl/pwm_audio_out_if.sv
// pwm_audio_out_if: signal bundle between the mixer side and the PWM output stage.
//   sample_in  [7:0] unsigned mixed sample; must be valid while sample_req is high
//   mute             level-sensitive mute request
//   pwm_out          registered PWM bit toward the RC filter
//   sample_req       one-cycle strobe, the cycle in which sample_in and mute are taken
//   muted            high while the output stage sits in silence
// master: mixer / control side.  slave: pwm_audio_out.
interface pwm_audio_out_if;
  logic [7:0] sample_in;
  logic       mute;
  logic       pwm_out;
  logic       sample_req;
  logic       muted;

  modport master (output sample_in, mute, input pwm_out, sample_req, muted);
  modport slave  (input sample_in, mute, output pwm_out, sample_req, muted);
endinterface

// File: rtl/pwm_audio_out.sv
// pwm_audio_out: sound card output stage.
// Holds each 8-bit mixed sample for one 256-clock PWM period and drives a single
// PWM bit for an external RC low-pass. The mixer is paced by sample_req, which
// marks the only cycle (count == 255) in which sample_in and mute are looked at.
//
// Build option: define SOFT_MUTE_EN to get the pop-free fade-in/fade-out ramp
// (level moves by STEP per period). Without it, mute/unmute switch the level
// straight between 0 and the sample at the next period boundary.
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-high; clears all state immediately
//   aud    pwm_audio_out_if.slave (sample_in, mute in; pwm_out, sample_req, muted out)
// Parameters:
//   STEP   level change per PWM period while fading (1..255)
module pwm_audio_out #(
  parameter int STEP = 4
) (
  input  logic            clk,
  input  logic            reset,
  pwm_audio_out_if.slave  aud
);

  if (STEP < 1 || STEP > 255) begin : g_bad_step
    $error("pwm_audio_out: STEP must be in 1..255");
  end

`ifdef SOFT_MUTE_EN
  typedef enum logic [1:0] {
    SILENT   = 2'd0,
    FADE_IN  = 2'd1,
    PLAY     = 2'd2,
    FADE_OUT = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    SILENT = 2'd0,
    PLAY   = 2'd2
  } state_t;
`endif

  logic [7:0] count;
  logic [7:0] level, level_nxt;
  state_t     state, state_nxt;
  logic       pwm_q, req_q, muted_q;
  logic       boundary;

  assign boundary = (count == 8'hFF);

`ifdef SOFT_MUTE_EN
  localparam logic [7:0] STEP8 = 8'(STEP);

  // Upward ramp step. SILENT ramps from 0 regardless of what level holds.
  // The sum is 9 bits so a large level plus STEP cannot wrap; once it reaches
  // the sample we land exactly on it and start tracking.
  logic [7:0] up_base;
  logic [8:0] up_sum;
  logic       up_done;
  logic [7:0] up_lvl;
  logic [7:0] dn_lvl;

  assign up_base = (state == SILENT) ? 8'd0 : level;
  assign up_sum  = {1'b0, up_base} + {1'b0, STEP8};
  assign up_done = (up_sum >= {1'b0, aud.sample_in});
  assign up_lvl  = up_done ? aud.sample_in : up_sum[7:0];
  // Saturating downward step, clamps at 0.
  assign dn_lvl  = (level > STEP8) ? (level - STEP8) : 8'd0;

  always_comb begin
    state_nxt = state;
    level_nxt = level;
    if (boundary) begin
      unique case (state)
        SILENT: begin
          level_nxt = 8'd0;
          if (!aud.mute) begin
            level_nxt = up_lvl;
            state_nxt = up_done ? PLAY : FADE_IN;
          end
        end
        FADE_IN: begin
          if (aud.mute) begin
            level_nxt = dn_lvl;
            state_nxt = FADE_OUT;
          end else begin
            level_nxt = up_lvl;
            state_nxt = up_done ? PLAY : FADE_IN;
          end
        end
        PLAY: begin
          if (aud.mute) begin
            level_nxt = dn_lvl;
            state_nxt = FADE_OUT;
          end else begin
            level_nxt = aud.sample_in;
          end
        end
        FADE_OUT: begin
          if (!aud.mute) begin
            // Reverse from the current level; no jump.
            level_nxt = up_lvl;
            state_nxt = up_done ? PLAY : FADE_IN;
          end else begin
            level_nxt = dn_lvl;
            if (dn_lvl == 8'd0) state_nxt = SILENT;
          end
        end
        default: begin
          level_nxt = 8'd0;
          state_nxt = SILENT;
        end
      endcase
    end
  end
`else
  always_comb begin
    state_nxt = state;
    level_nxt = level;
    if (boundary) begin
      unique case (state)
        SILENT: begin
          level_nxt = 8'd0;
          if (!aud.mute) begin
            level_nxt = aud.sample_in;
            state_nxt = PLAY;
          end
        end
        PLAY: begin
          if (aud.mute) begin
            level_nxt = 8'd0;
            state_nxt = SILENT;
          end else begin
            level_nxt = aud.sample_in;
          end
        end
        default: begin
          level_nxt = 8'd0;
          state_nxt = SILENT;
        end
      endcase
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count   <= 8'd0;
      level   <= 8'd0;
      state   <= SILENT;
      pwm_q   <= 1'b0;
      req_q   <= 1'b0;
      muted_q <= 1'b1;
    end else begin
      count   <= count + 8'd1;
      level   <= level_nxt;
      state   <= state_nxt;
      // Level updated at the boundary is already in use at count == 0.
      pwm_q   <= (count < level);
      // Registered strobe, lined up with the cycle where count == 255.
      req_q   <= (count == 8'hFE);
      muted_q <= (state_nxt == SILENT);
    end
  end

  assign aud.pwm_out    = pwm_q;
  assign aud.sample_req = req_q;
  assign aud.muted      = muted_q;

endmodule
